// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_e;

    localparam int   SCORE_W   = 4;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// Rising-edge pulse generator with an optional two-flop synchroniser in front
// (SYNC=1 for asynchronous pins such as buttons).
module pong_edge_detect #(
    parameter bit SYNC = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_sig,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic level;

    always_comb begin
        sync1_d = in_sig;
        sync2_d = sync1_q;
        level   = SYNC ? sync2_q : in_sig;
        prev_d  = level;
        pulse   = level & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: attract/serve/rally/point-pause/game-over phases timed
// in video frames, score keeping, and ball run/reset/direction controls.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int OVER_FRAMES  = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic               winner
);

    localparam int CNT_MAX = max3(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    logic frame_tick;
    logic start_pulse;

    pong_edge_detect #(.SYNC(1'b0)) u_vsync_edge (
        .clk    (clk),
        .reset  (reset),
        .in_sig (vsync),
        .pulse  (frame_tick)
    );

    pong_edge_detect #(.SYNC(1'b1)) u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .in_sig (start),
        .pulse  (start_pulse)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               ball_run_q, ball_run_d;
    logic               ball_reset_q, ball_reset_d;
    logic               game_over_q, game_over_d;
    logic [SCORE_W-1:0] score_inc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        score_inc   = '0;

        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_dir_d = DIR_RIGHT;
                    state_d     = SERVE;
                    cnt_d       = '0;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            PLAY: begin
                // A simultaneous miss on both sides is a draw: no score, same server.
                if (miss_left && miss_right) begin
                    state_d = POINT;
                    cnt_d   = '0;
                end else if (miss_left || miss_right) begin
                    score_inc = miss_left ? (score2_q + SCORE_ONE) : (score1_q + SCORE_ONE);
                    if (miss_left) begin
                        score2_d    = score_inc;
                        serve_dir_d = DIR_LEFT;
                    end else begin
                        score1_d    = score_inc;
                        serve_dir_d = DIR_RIGHT;
                    end
                    cnt_d = '0;
                    if (score_inc == WIN) begin
                        state_d  = OVER;
                        winner_d = miss_left;
                    end else begin
                        state_d = POINT;
                    end
                end
            end
            POINT: begin
                if (frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        state_d = SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            OVER: begin
                if (start_pulse) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_dir_d = DIR_RIGHT;
                    state_d     = SERVE;
                    cnt_d       = '0;
                end else if (frame_tick) begin
                    if (cnt_q == OVER_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ball_run_d   = (state_d == PLAY);
        ball_reset_d = (state_d == IDLE) || (state_d == SERVE) || (state_d == OVER);
        game_over_d  = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            score1_q     <= '0;
            score2_q     <= '0;
            serve_dir_q  <= DIR_RIGHT;
            winner_q     <= 1'b0;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
        end
    end

    assign ball_run   = ball_run_q;
    assign ball_reset = ball_reset_q;
    assign serve_dir  = serve_dir_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with short frame counts
// (SERVE=2, POINT=1, OVER=3, WIN=2).
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       start = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;

    int compare_count = 0;
    int mismatch_count = 0;

    pong_game_ctrl #(
        .WIN_SCORE    (2),
        .SERVE_FRAMES (2),
        .POINT_FRAMES (1),
        .OVER_FRAMES  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .start      (start),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score1     (score1),
        .score2     (score2),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle vsync high; the frame tick lands on the edge that samples it.
    task automatic pulseVsync();
        vsync = 1'b1;
        stepCycles(1);
        vsync = 1'b0;
        stepCycles(2);
    endtask

    task automatic pressStart();
        start = 1'b1;
        stepCycles(4);
        start = 1'b0;
        stepCycles(2);
    endtask

    task automatic pulseMiss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        stepCycles(1);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic checkIdleLike(input string tag, input logic [3:0] s1, input logic [3:0] s2);
        checkOutput({tag, "_ball_reset"}, {7'd0, ball_reset}, 8'd1);
        checkOutput({tag, "_ball_run"},   {7'd0, ball_run},   8'd0);
        checkOutput({tag, "_game_over"},  {7'd0, game_over},  8'd0);
        checkOutput({tag, "_score1"},     {4'd0, score1},     {4'd0, s1});
        checkOutput({tag, "_score2"},     {4'd0, score2},     {4'd0, s2});
    endtask

    task automatic checkPlay(input string tag, input logic dir);
        checkOutput({tag, "_ball_run"},   {7'd0, ball_run},   8'd1);
        checkOutput({tag, "_ball_reset"}, {7'd0, ball_reset}, 8'd0);
        checkOutput({tag, "_serve_dir"},  {7'd0, serve_dir},  {7'd0, dir});
    endtask

    task automatic checkPoint(input string tag, input logic [3:0] s1, input logic [3:0] s2, input logic dir);
        checkOutput({tag, "_ball_run"},   {7'd0, ball_run},   8'd0);
        checkOutput({tag, "_ball_reset"}, {7'd0, ball_reset}, 8'd0);
        checkOutput({tag, "_score1"},     {4'd0, score1},     {4'd0, s1});
        checkOutput({tag, "_score2"},     {4'd0, score2},     {4'd0, s2});
        checkOutput({tag, "_serve_dir"},  {7'd0, serve_dir},  {7'd0, dir});
    endtask

    // POINT -> SERVE on one frame, then SERVE -> PLAY after two more.
    task automatic applyStimulus(input string tag, input logic dir);
        pulseVsync();
        checkOutput({tag, "_serve_reset"}, {7'd0, ball_reset}, 8'd1);
        pulseVsync();
        checkOutput({tag, "_serve_hold"}, {7'd0, ball_run}, 8'd0);
        pulseVsync();
        checkPlay({tag, "_play"}, dir);
    endtask

    initial begin
        stepCycles(3);
        checkIdleLike("reset", 4'd0, 4'd0);
        checkOutput("reset_serve_dir", {7'd0, serve_dir}, 8'd0);
        checkOutput("reset_winner",    {7'd0, winner},    8'd0);
        reset = 1'b0;
        stepCycles(1);

        repeat (5) pulseVsync();
        checkIdleLike("idle_5frames", 4'd0, 4'd0);

        pressStart();
        pulseVsync();
        checkOutput("serve_tick1_run", {7'd0, ball_run}, 8'd0);
        pulseVsync();
        checkPlay("first_play", 1'b0);

        pressStart();
        checkPlay("start_in_play", 1'b0);

        pulseMiss(1'b1, 1'b0);
        checkPoint("miss_left", 4'd0, 4'd1, 1'b1);
        applyStimulus("rally2", 1'b1);

        pulseMiss(1'b1, 1'b1);
        checkPoint("draw", 4'd0, 4'd1, 1'b1);
        applyStimulus("rally3", 1'b1);

        // Miss coinciding with a frame tick still scores.
        vsync = 1'b1;
        pulseMiss(1'b0, 1'b1);
        vsync = 1'b0;
        stepCycles(2);
        checkPoint("miss_right_tick", 4'd1, 4'd1, 1'b0);
        applyStimulus("rally4", 1'b0);

        pulseMiss(1'b0, 1'b1);
        checkOutput("win_score1",    {4'd0, score1},     8'd2);
        checkOutput("win_game_over", {7'd0, game_over},  8'd1);
        checkOutput("win_winner",    {7'd0, winner},     8'd0);
        checkOutput("win_ball_run",  {7'd0, ball_run},   8'd0);
        checkOutput("win_ball_reset",{7'd0, ball_reset}, 8'd1);

        pulseMiss(1'b1, 1'b0);
        checkOutput("miss_in_over", {4'd0, score2}, 8'd1);

        pulseVsync();
        pulseVsync();
        checkOutput("over_2frames", {7'd0, game_over}, 8'd1);
        pulseVsync();
        checkIdleLike("over_to_idle", 4'd2, 4'd1);

        pressStart();
        checkIdleLike("restart", 4'd0, 4'd0);
        pulseVsync();
        pulseVsync();
        checkPlay("restart_play", 1'b0);

        pulseMiss(1'b1, 1'b0);
        applyStimulus("rally5", 1'b1);
        pulseMiss(1'b0, 1'b1);
        applyStimulus("rally6", 1'b0);
        checkOutput("pre_reset_s1", {4'd0, score1}, 8'd1);
        checkOutput("pre_reset_s2", {4'd0, score2}, 8'd1);

        reset     = 1'b1;
        miss_left = 1'b1;
        stepCycles(1);
        miss_left = 1'b0;
        checkIdleLike("mid_reset", 4'd0, 4'd0);
        checkOutput("mid_reset_serve_dir", {7'd0, serve_dir}, 8'd0);
        checkOutput("mid_reset_winner",    {7'd0, winner},    8'd0);
        reset = 1'b0;
        stepCycles(1);
        pulseVsync();
        pulseVsync();
        pulseVsync();
        checkIdleLike("post_reset_idle", 4'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
